// File: rtl/controlador_entrada_pkg.sv
// Shared constants and types for the IN-instruction controller, the input mux and the control unit.
// No logic here; select codes and switch width must stay in sync with the register-file input mux.
package controlador_entrada_pkg;

    localparam int LARGURA_CHAVES = 14;

    // Register-file write-data mux select codes; 2'd2/2'd3 are reserved.
    localparam logic [1:0] SEL_MEM_ULA = 2'd0;
    localparam logic [1:0] SEL_ENTRADA = 2'd1;

    typedef logic [LARGURA_CHAVES-1:0] chaves_t;

    typedef enum logic [1:0] {
        OCIOSO           = 2'd0,
        ESPERA_SOLTAR    = 2'd1,
        ESPERA_PRESSIONA = 2'd2,
        CAPTURA          = 2'd3
    } estado_t;

endpackage

// File: rtl/filtro_botao.sv
// Confirm-button conditioning: 2-flop synchronizer, then a debounce counter when CONTROLADOR_ENTRADA_DEBOUNCE_EN is defined.
// Latency: 2 cycles to the synchronized level, plus DEBOUNCE_CICLOS with the filter enabled.
// Backpressure: none; free-running level filter.
module filtro_botao #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_n,
    output logic pressionado
);

    if (DEBOUNCE_CICLOS < 1) begin : g_debounce_invalido
        $error("filtro_botao: DEBOUNCE_CICLOS must be at least 1");
    end

    logic sinc_1;
    logic sinc_2;

    // Reset to 1 so the button reads as released until real samples arrive.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_1 <= 1'b1;
            sinc_2 <= 1'b1;
        end else begin
            sinc_1 <= botao_n;
            sinc_2 <= sinc_1;
        end
    end

`ifdef CONTROLADOR_ENTRADA_DEBOUNCE_EN
    localparam int LARG_CONT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(DEBOUNCE_CICLOS - 1);

    logic [LARG_CONT-1:0] contador;
    logic                 filtrado;

    // Any sample agreeing with the filtered level restarts the count, so only
    // DEBOUNCE_CICLOS consecutive disagreeing samples flip the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            filtrado <= 1'b1;
            contador <= '0;
        end else if (sinc_2 == filtrado) begin
            contador <= '0;
        end else if (contador == CONT_MAX) begin
            filtrado <= sinc_2;
            contador <= '0;
        end else begin
            contador <= contador + LARG_CONT'(1);
        end
    end

    assign pressionado = ~filtrado;
`else
    assign pressionado = ~sinc_2;
`endif

endmodule

// File: rtl/controlador_entrada.sv
// IN-instruction sequencer: stalls the core, waits for a fresh confirm press, latches the switches and strobes one register write.
// Latency: parar_pc rises one cycle after instr_entrada; CAPTURA follows a clean press by 3 cycles (+DEBOUNCE_CICLOS with CONTROLADOR_ENTRADA_DEBOUNCE_EN).
// Backpressure: none accepted; the controller itself back-pressures the core through parar_pc.
module controlador_entrada
    import controlador_entrada_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instr_entrada,
    input  logic [LARGURA_CHAVES-1:0] chaves,
    input  logic                      botao_n,
    output logic [1:0]                in,
    output logic [LARGURA_CHAVES-1:0] dado_lido_entrada,
    output logic                      escrita_entrada,
    output logic                      parar_pc,
    output logic                      aguardando
);

    // The mux zero-extends dado_lido_entrada, so the datapath must hold the whole switch bank.
    if (DATA_WIDTH < LARGURA_CHAVES) begin : g_largura_invalida
        $error("controlador_entrada: DATA_WIDTH must be at least 14");
    end

    logic    pressionado;
    logic    pressionado_d1;
    logic    borda;
    estado_t estado;

    filtro_botao #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro (
        .clock      (clock),
        .reset      (reset),
        .botao_n    (botao_n),
        .pressionado(pressionado)
    );

    assign borda = pressionado & ~pressionado_d1;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado            <= OCIOSO;
            pressionado_d1    <= 1'b0;
            in                <= SEL_MEM_ULA;
            dado_lido_entrada <= '0;
            escrita_entrada   <= 1'b0;
            parar_pc          <= 1'b0;
            aguardando        <= 1'b0;
        end else begin
            pressionado_d1  <= pressionado;
            in              <= SEL_MEM_ULA;
            escrita_entrada <= 1'b0;

            case (estado)
                OCIOSO: begin
                    if (instr_entrada) begin
                        parar_pc <= 1'b1;
                        // A press already in progress belongs to an earlier action.
                        if (pressionado) begin
                            estado     <= ESPERA_SOLTAR;
                            aguardando <= 1'b0;
                        end else begin
                            estado     <= ESPERA_PRESSIONA;
                            aguardando <= 1'b1;
                        end
                    end else begin
                        parar_pc   <= 1'b0;
                        aguardando <= 1'b0;
                    end
                end

                ESPERA_SOLTAR: begin
                    if (!instr_entrada) begin
                        estado     <= OCIOSO;
                        parar_pc   <= 1'b0;
                        aguardando <= 1'b0;
                    end else if (!pressionado) begin
                        estado     <= ESPERA_PRESSIONA;
                        aguardando <= 1'b1;
                    end
                end

                ESPERA_PRESSIONA: begin
                    // Losing the instruction outranks a simultaneous press.
                    if (!instr_entrada) begin
                        estado     <= OCIOSO;
                        parar_pc   <= 1'b0;
                        aguardando <= 1'b0;
                    end else if (borda) begin
                        estado            <= CAPTURA;
                        dado_lido_entrada <= chaves;
                        in                <= SEL_ENTRADA;
                        escrita_entrada   <= 1'b1;
                        parar_pc          <= 1'b0;
                        aguardando        <= 1'b0;
                    end
                end

                CAPTURA: begin
                    estado     <= OCIOSO;
                    parar_pc   <= 1'b0;
                    aguardando <= 1'b0;
                end

                default: begin
                    estado     <= OCIOSO;
                    parar_pc   <= 1'b0;
                    aguardando <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_entrada.sv
// Bench for controlador_entrada: directed scenarios plus randomized button/instruction traffic against a behavioural model.
module tb_controlador_entrada;

    localparam int N = 8;
`ifdef CONTROLADOR_ENTRADA_DEBOUNCE_EN
    localparam int LAT = 3 + N;
`else
    localparam int LAT = 3;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_entrada;
    logic [13:0] chaves;
    logic        botao_n;
    logic [1:0]  sel_in;
    logic [13:0] dado_lido_entrada;
    logic        escrita_entrada;
    logic        parar_pc;
    logic        aguardando;

    int total;
    int bad;
    logic [13:0] ultimo_dado;

    controlador_entrada #(
        .DATA_WIDTH     (32),
        .DEBOUNCE_CICLOS(N)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .instr_entrada    (instr_entrada),
        .chaves           (chaves),
        .botao_n          (botao_n),
        .in               (sel_in),
        .dado_lido_entrada(dado_lido_entrada),
        .escrita_entrada  (escrita_entrada),
        .parar_pc         (parar_pc),
        .aguardando       (aguardando)
    );

    always #5 clock = ~clock;

    // Reference model: button history as a sample queue, the IN request as a few booleans.
    bit          amostras[$];
    bit          filt_m;
    bit          p_ant;
    bit          em_espera;
    bit          liberado;
    bit          esp_strobe;
    logic [13:0] esp_dado;

    always @(posedge clock) begin : modelo
        bit p_now;
        bit borda_m;
        bit todos_diferem;
        p_now   = !filt_m;
        borda_m = p_now && !p_ant;
        if (reset) begin
            em_espera  = 0;
            liberado   = 0;
            esp_strobe = 0;
            esp_dado   = '0;
            p_ant      = 0;
            filt_m     = 1;
            for (int i = 0; i < amostras.size(); i++) amostras[i] = 1;
        end else begin
            if (esp_strobe) begin
                esp_strobe = 0;
            end else if (!em_espera) begin
                if (instr_entrada) begin
                    em_espera = 1;
                    liberado  = !p_now;
                end
            end else if (!instr_entrada) begin
                em_espera = 0;
            end else if (!liberado) begin
                liberado = !p_now;
            end else if (borda_m) begin
                esp_strobe = 1;
                esp_dado   = chaves;
                em_espera  = 0;
            end
            p_ant = p_now;
            amostras.push_back(botao_n);
            void'(amostras.pop_front());
`ifdef CONTROLADOR_ENTRADA_DEBOUNCE_EN
            todos_diferem = 1;
            for (int k = 0; k < N; k++)
                if (amostras[amostras.size()-3-k] == filt_m) todos_diferem = 0;
            if (todos_diferem) filt_m = !filt_m;
`else
            todos_diferem = 0;
            filt_m = amostras[amostras.size()-2];
`endif
        end
    end

    logic [18:0] obs;
    logic [18:0] esp;
    assign obs = {sel_in, escrita_entrada, parar_pc, aguardando, dado_lido_entrada};
    assign esp = {1'b0, esp_strobe, esp_strobe, em_espera, em_espera & liberado, esp_dado};

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; botao_n = 0; instr_entrada = 1; chaves = 14'($urandom);
        for (int c = 1; c <= 3; c++) begin
            ciclo();
            total++;
            if (obs !== 19'd0) begin bad++; $display("FAIL reset_hold c=%0d: got %h expected 0", c, obs); end
        end
        reset = 0; botao_n = 1; instr_entrada = 0;
        for (int c = 1; c <= LAT + 3; c++) begin
            ciclo();
            total++;
            if (obs !== 19'd0 || obs !== esp) begin bad++; $display("FAIL reset_release c=%0d: got %h expected 0 (model %h)", c, obs, esp); end
        end
        ultimo_dado = '0;
    endtask

    task automatic test_basico();
        int n = 0, ts = -1;
        chaves = 14'h2A5B; instr_entrada = 1; botao_n = 1;
        for (int c = 1; c <= 10 + LAT + 10; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL basico_model c=%0d: got %h expected %h", c, obs, esp); end
            if (c == 1) begin
                total++;
                if (parar_pc !== 1'b1 || aguardando !== 1'b1) begin bad++; $display("FAIL basico_stall: got parar=%b aguard=%b expected 1 1", parar_pc, aguardando); end
            end
            if (escrita_entrada === 1'b1) begin
                n++; ts = c; instr_entrada = 0;
                total++;
                if (sel_in !== 2'd1 || parar_pc !== 1'b0 || dado_lido_entrada !== 14'h2A5B) begin
                    bad++; $display("FAIL basico_strobe: got in=%0d parar=%b dado=%h expected 1 0 2a5b", sel_in, parar_pc, dado_lido_entrada);
                end
            end
            if (c == 10) botao_n = 0;
        end
        total++;
        if (n != 1 || ts != 10 + LAT) begin bad++; $display("FAIL basico_count: got n=%0d at %0d expected 1 at %0d", n, ts, 10 + LAT); end
        ultimo_dado = 14'h2A5B;
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask

    task automatic test_segurado();
        int n = 0, ts = -1;
        int rel = 15, pr = 15 + LAT + 3;
        logic [13:0] v = 14'($urandom);
        botao_n = 0;
        for (int c = 1; c <= LAT + 2; c++) ciclo();
        chaves = v; instr_entrada = 1;
        for (int c = 1; c <= pr + LAT + 5; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL segurado_model c=%0d: got %h expected %h", c, obs, esp); end
            if (c < rel + LAT) begin
                total++;
                if (aguardando !== 1'b0 || parar_pc !== 1'b1) begin bad++; $display("FAIL segurado_held c=%0d: got aguard=%b parar=%b expected 0 1", c, aguardando, parar_pc); end
            end
            if (escrita_entrada === 1'b1) begin
                n++; ts = c; instr_entrada = 0;
                total++;
                if (dado_lido_entrada !== v) begin bad++; $display("FAIL segurado_dado: got %h expected %h", dado_lido_entrada, v); end
            end
            if (c == rel) botao_n = 1;
            if (c == pr) botao_n = 0;
        end
        total++;
        if (n != 1 || ts != pr + LAT) begin bad++; $display("FAIL segurado_count: got n=%0d at %0d expected 1 at %0d", n, ts, pr + LAT); end
        ultimo_dado = v;
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask

    task automatic test_queda();
        int n = 0;
        int d = 5 + LAT - 1;
        chaves = ~ultimo_dado; instr_entrada = 1; botao_n = 1;
        for (int c = 1; c <= d + 15; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL queda_model c=%0d: got %h expected %h", c, obs, esp); end
            if (c == d) begin
                total++;
                if (aguardando !== 1'b1) begin bad++; $display("FAIL queda_waiting: got aguard=%b expected 1", aguardando); end
            end
            if (c == d + 1) begin
                total++;
                if (parar_pc !== 1'b0 || aguardando !== 1'b0 || escrita_entrada !== 1'b0 || dado_lido_entrada !== ultimo_dado) begin
                    bad++; $display("FAIL queda_abort: got parar=%b aguard=%b esc=%b dado=%h expected 0 0 0 %h", parar_pc, aguardando, escrita_entrada, dado_lido_entrada, ultimo_dado);
                end
            end
            if (escrita_entrada === 1'b1) n++;
            if (c == 5) botao_n = 0;
            if (c == d) instr_entrada = 0;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL queda_strobe: got %0d strobes expected 0", n); end
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int s1 = 3 + LAT;
        int rel = s1 + 15;
        int pr = rel + LAT + 3;
        int s2 = pr + LAT;
        chaves = 14'h0001; instr_entrada = 1; botao_n = 1;
        for (int c = 1; c <= s2 + 5; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL b2b_model c=%0d: got %h expected %h", c, obs, esp); end
            if (escrita_entrada === 1'b1) begin
                n++;
                total++;
                if (n == 1) begin
                    if (c != s1 || dado_lido_entrada !== 14'h0001) begin bad++; $display("FAIL b2b_first: got c=%0d dado=%h expected c=%0d 0001", c, dado_lido_entrada, s1); end
                    chaves = 14'h3FFF;
                end else begin
                    if (c != s2 || dado_lido_entrada !== 14'h3FFF) begin bad++; $display("FAIL b2b_second: got c=%0d dado=%h expected c=%0d 3fff", c, dado_lido_entrada, s2); end
                    instr_entrada = 0;
                end
            end
            if (c >= s1 + 2 && c < rel + LAT) begin
                total++;
                if (aguardando !== 1'b0 || parar_pc !== 1'b1) begin bad++; $display("FAIL b2b_held c=%0d: got aguard=%b parar=%b expected 0 1", c, aguardando, parar_pc); end
            end
            if (c == 3) botao_n = 0;
            if (c == rel) botao_n = 1;
            if (c == pr) botao_n = 0;
        end
        total++;
        if (n != 2) begin bad++; $display("FAIL b2b_count: got %0d strobes expected 2", n); end
        ultimo_dado = 14'h3FFF;
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask

`ifdef CONTROLADOR_ENTRADA_DEBOUNCE_EN
    task automatic test_bounce();
        int n = 0, ts = -1;
        logic [13:0] v = 14'($urandom);
        chaves = v; instr_entrada = 1; botao_n = 1;
        for (int c = 1; c <= 14 + LAT + 5; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL bounce_model c=%0d: got %h expected %h", c, obs, esp); end
            if (escrita_entrada === 1'b1) begin n++; ts = c; instr_entrada = 0; end
            if (c == 2 || c == 8) botao_n = 0;
            if (c == 5 || c == 11) botao_n = 1;
            if (c == 14) botao_n = 0;
        end
        total++;
        if (n != 1 || ts != 14 + N + 3) begin bad++; $display("FAIL bounce_count: got n=%0d at %0d expected 1 at %0d", n, ts, 14 + N + 3); end
        ultimo_dado = v;
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask
`endif

    task automatic test_reset_meio();
        int n = 0;
        int r = 4 + LAT - 1;
        chaves = 14'($urandom); instr_entrada = 1; botao_n = 1;
        for (int c = 1; c <= r + 15; c++) begin
            ciclo();
            total++;
            if (obs !== esp) begin bad++; $display("FAIL reset_meio_model c=%0d: got %h expected %h", c, obs, esp); end
            if (escrita_entrada === 1'b1) n++;
            if (c == r + 1) begin
                total++;
                if (obs !== 19'd0) begin bad++; $display("FAIL reset_meio_clear: got %h expected 0", obs); end
                reset = 0; instr_entrada = 0;
            end
            if (c == 4) botao_n = 0;
            if (c == r) reset = 1;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL reset_meio_strobe: got %0d strobes expected 0", n); end
        ultimo_dado = '0;
        botao_n = 1;
        for (int c = 1; c <= LAT + 3; c++) ciclo();
    endtask

    task automatic test_aleatorio();
        for (int it = 0; it < 25; it++) begin
            int a = $urandom_range(1, 12);
            int h = $urandom_range(1, N + 6);
            int q = $urandom_range(a, a + LAT + 20);
            chaves = 14'($urandom); instr_entrada = 1; botao_n = 1;
            for (int c = 1; c <= 50; c++) begin
                ciclo();
                total++;
                if (obs !== esp) begin bad++; $display("FAIL aleatorio_model it=%0d c=%0d: got %h expected %h", it, c, obs, esp); end
                if (escrita_entrada === 1'b1) instr_entrada = 0;
                if (c == a) botao_n = 0;
                if (c == a + h) botao_n = 1;
                if (c == q) instr_entrada = 0;
                if ($urandom_range(0, 9) == 0) chaves = 14'($urandom);
                if ($urandom_range(0, 15) == 0) botao_n = ~botao_n;
            end
            botao_n = 1; instr_entrada = 0;
            for (int c = 1; c <= LAT + N + 4; c++) begin
                ciclo();
                total++;
                if (obs !== esp) begin bad++; $display("FAIL aleatorio_settle it=%0d c=%0d: got %h expected %h", it, c, obs, esp); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1; instr_entrada = 0; botao_n = 1; chaves = '0; ultimo_dado = '0;
        filt_m = 1; p_ant = 0; em_espera = 0; liberado = 0; esp_strobe = 0; esp_dado = '0;
        for (int i = 0; i < N + 4; i++) amostras.push_back(1'b1);

        test_reset();
        test_basico();
        test_segurado();
        test_queda();
        test_back_to_back();
`ifdef CONTROLADOR_ENTRADA_DEBOUNCE_EN
        test_bounce();
`endif
        test_reset_meio();
        test_aleatorio();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
